// File: rtl/sys_bridge_pkg.sv
// Shared definitions for the processor-bus bridge: register map, CTRL fields,
// timer modes and timer FSM states.
package sys_bridge_pkg;

    localparam logic [31:0] TIMER0_BASE_DEFAULT = 32'h0000_7F00;
    localparam logic [31:0] TIMER1_BASE_DEFAULT = 32'h0000_7F10;

    // Word offsets within a 16-byte timer window (PrAddr[3:2]).
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_AUTO    = 2'b01
    } timer_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } timer_state_e;

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:4] == base[31:4];
    endfunction

endpackage

// File: rtl/sys_bridge_timer_counter.sv
// One memory-mapped countdown timer: CTRL/PRESET/COUNT registers, the
// IDLE/LOAD/CNT/INT sequencer and the pending flag behind its interrupt.
module timer_counter
    import sys_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [1:0]  offset,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]   ctrl;
    logic [31:0]  preset;
    logic [31:0]  count;
    logic         pending;
    timer_state_e state;

    logic ctrl_wr;
    logic preset_wr;
    logic auto_reload;

    assign ctrl_wr     = sel && we && (offset == OFF_CTRL);
    assign preset_wr   = sel && we && (offset == OFF_PRESET);
    assign auto_reload = (ctrl[CTRL_MODE_LSB+1:CTRL_MODE_LSB] == MODE_AUTO);
    assign irq         = pending & ctrl[CTRL_IM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ctrl[CTRL_EN]) state <= ST_LOAD;
                ST_LOAD: begin
                    // A zero preset counts like a preset of one.
                    count <= (preset == '0) ? 32'd1 : preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count   <= '0;
                        pending <= 1'b1;
                        state   <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (auto_reload) begin
                        pending <= 1'b0;
                        state   <= ST_LOAD;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // NOTE: all updates here are non-blocking, so the CPU write below,
            // being the last assignment, overrides the FSM's Enable clear and
            // pending set when both land on the same edge.
            if (ctrl_wr) begin
                ctrl    <= wdata[3:0];
                pending <= 1'b0;
            end
            if (preset_wr) preset <= wdata;
        end
    end

    // NOTE: rdata gets a default before the case so no latch is inferred.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                OFF_CTRL:   rdata = {28'd0, ctrl};
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/sys_bridge.sv
// Processor-bus bridge: decodes PrAddr to timer windows, returns PrRD and builds
// HWInt[7:2]. Timer 1 exists only when SYS_BRIDGE_TIMER1_EN is defined.
module sys_bridge
    import sys_bridge_pkg::*;
#(
    parameter logic [31:0] TIMER0_BASE     = TIMER0_BASE_DEFAULT,
    parameter logic [31:0] TIMER1_BASE     = TIMER1_BASE_DEFAULT,
    parameter int          EXT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic        PrWE,
    output logic [31:0] PrRD,
    input  logic [3:0]  ExtInt,
    output logic [7:2]  HWInt
);

    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        irq0;
    logic        irq1;
    logic        unused_addr_bits;

    logic [EXT_SYNC_STAGES-1:0][3:0] ext_sync;

    assign unused_addr_bits = ^PrAddr[1:0];

    timer_counter u_timer0 (
        .clk    (clk),
        .rst_n  (reset),
        .sel    (in_window(PrAddr, TIMER0_BASE)),
        .offset (PrAddr[3:2]),
        .we     (PrWE),
        .wdata  (PrWD),
        .rdata  (rd0),
        .irq    (irq0)
    );

`ifdef SYS_BRIDGE_TIMER1_EN
    timer_counter u_timer1 (
        .clk    (clk),
        .rst_n  (reset),
        .sel    (in_window(PrAddr, TIMER1_BASE)),
        .offset (PrAddr[3:2]),
        .we     (PrWE),
        .wdata  (PrWD),
        .rdata  (rd1),
        .irq    (irq1)
    );
`else
    logic unused_timer1_hit;
    assign unused_timer1_hit = in_window(PrAddr, TIMER1_BASE);
    assign rd1  = '0;
    assign irq1 = 1'b0;
`endif

    // Each timer drives zero unless selected, so the read path is a plain OR.
    assign PrRD = rd0 | rd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ext_sync <= '0;
        else        ext_sync <= {ext_sync[EXT_SYNC_STAGES-2:0], ExtInt};
    end

    assign HWInt = {ext_sync[EXT_SYNC_STAGES-1], irq1, irq0};

endmodule

// File: tb/tb_sys_bridge.sv
// Self-checking bench for sys_bridge: directed and randomized timer scenarios
// checked against timing formulas, plus an ExtInt history model.
module tb_sys_bridge;

    localparam int          SYNC = 2;
    localparam logic [31:0] T0B  = 32'h0000_7F00;
    localparam logic [31:0] T1B  = 32'h0000_7F10;
`ifdef SYS_BRIDGE_TIMER1_EN
    localparam bit HAS_T1 = 1'b1;
`else
    localparam bit HAS_T1 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic        PrWE;
    logic [31:0] PrRD;
    logic [3:0]  ExtInt;
    logic [7:2]  HWInt;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          ext_rand = 1'b0;
    logic [3:0]  ext_hist[$];

    sys_bridge #(
        .TIMER0_BASE     (T0B),
        .TIMER1_BASE     (T1B),
        .EXT_SYNC_STAGES (SYNC)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .PrAddr (PrAddr),
        .PrWD   (PrWD),
        .PrWE   (PrWE),
        .PrRD   (PrRD),
        .ExtInt (ExtInt),
        .HWInt  (HWInt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_hist();
        ext_hist.delete();
        repeat (SYNC) ext_hist.push_back(4'h0);
    endtask

    // One clock: present a bus cycle, take the edge, then check the ExtInt path.
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        PrWE   = we;
        PrAddr = addr;
        PrWD   = wd;
        if (ext_rand) ExtInt = 4'($urandom);
        @(posedge clk);
        ext_hist.push_back(ExtInt);
        if (ext_hist.size() > 8) void'(ext_hist.pop_front());
        #1;
        PrWE = 1'b0;
        check("ext_sync", {28'd0, HWInt[7:4]}, {28'd0, ext_hist[ext_hist.size()-SYNC]});
    endtask

    task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        PrAddr = addr;
        #1;
        check(tag, PrRD, exp);
    endtask

    task automatic irq_check(input string tag, input int sel, input logic b);
        logic [1:0] e;
        e = (sel == 1) ? {b, 1'b0} : {1'b0, b};
        check(tag, {30'd0, HWInt[3:2]}, {30'd0, e});
    endtask

    task automatic run_oneshot(input int sel, input int n, input logic im,
                               input logic [1:0] mode, input logic im_after);
        logic [31:0] base;
        logic [31:0] exp_cnt;
        bit          on;
        int          np;
        base = (sel == 1) ? T1B : T0B;
        on   = (sel == 0) || HAS_T1;
        np   = (n == 0) ? 1 : n;
        step(1'b1, base + 32'd4, 32'(n));
        step(1'b1, base, {28'd0, im, mode, 1'b1});
        for (int k = 1; k <= np + 4; k++) begin
            step(1'b0, base, 32'd0);
            if (k >= 2) begin
                exp_cnt = (k <= np + 1) ? 32'(np - (k - 2)) : 32'd0;
                peek("os_count", base + 32'd8, on ? exp_cnt : 32'd0);
            end
            peek("os_ctrl", base, on ? {28'd0, im, mode, k < np + 3} : 32'd0);
            irq_check("os_irq", sel, on && im && (k >= np + 2));
        end
        step(1'b1, base, {28'd0, im_after, 3'b000});
        peek("os_clear_ctrl", base, on ? {28'd0, im_after, 3'b000} : 32'd0);
        irq_check("os_clear_irq", sel, 1'b0);
        step(1'b0, base, 32'd0);
        irq_check("os_idle_irq", sel, 1'b0);
    endtask

    task automatic run_auto(input int sel, input int n, input logic im, input int periods);
        logic [31:0] base;
        logic [31:0] exp_cnt;
        bit          on;
        int          np;
        int          p;
        int          m;
        base = (sel == 1) ? T1B : T0B;
        on   = (sel == 0) || HAS_T1;
        np   = (n == 0) ? 1 : n;
        p    = np + 2;
        step(1'b1, base + 32'd4, 32'(n));
        step(1'b1, base, {28'd0, im, 3'b011});
        for (int k = 1; k <= periods * p + 2; k++) begin
            step(1'b0, base, 32'd0);
            m = (k - 1) % p;
            if (k >= 2) begin
                exp_cnt = (m >= 1 && m <= np) ? 32'(np - (m - 1)) : 32'd0;
                peek("ar_count", base + 32'd8, on ? exp_cnt : 32'd0);
            end
            peek("ar_ctrl", base, on ? {28'd0, im, 3'b011} : 32'd0);
            irq_check("ar_irq", sel, on && im && (m == np + 1));
        end
        step(1'b1, base, 32'd0);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step(1'b0, base, 32'd0);
            irq_check("ar_stop_irq", sel, 1'b0);
        end
        peek("ar_stop_ctrl", base, 32'd0);
    endtask

    task automatic run_disable(input int sel, input int n, input logic im,
                               input logic [1:0] mode, input int d);
        logic [31:0] base;
        logic [31:0] frozen;
        logic [31:0] ctrl_off;
        bit          on;
        base     = (sel == 1) ? T1B : T0B;
        on       = (sel == 0) || HAS_T1;
        frozen   = on ? 32'(n - (d - 2)) : 32'd0;
        ctrl_off = on ? {28'd0, im, mode, 1'b0} : 32'd0;
        step(1'b1, base + 32'd4, 32'(n));
        step(1'b1, base, {28'd0, im, mode, 1'b1});
        for (int k = 1; k < d; k++) begin
            step(1'b0, base, 32'd0);
            if (k >= 2) peek("dis_count", base + 32'd8, on ? 32'(n - (k - 2)) : 32'd0);
            irq_check("dis_run_irq", sel, 1'b0);
        end
        step(1'b1, base, {28'd0, im, mode, 1'b0});
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step(1'b0, base, 32'd0);
            peek("dis_frozen", base + 32'd8, frozen);
            irq_check("dis_irq", sel, 1'b0);
        end
        peek("dis_ctrl", base, ctrl_off);
        step(1'b1, base + 32'd8, $urandom);
        peek("count_ro", base + 32'd8, frozen);
        step(1'b1, 32'h0000_7F20, $urandom);
        peek("unmapped_rd", 32'h0000_7F20, 32'd0);
        peek("unmapped_wr", base + 32'd8, frozen);
        step(1'b1, base + 32'd12, $urandom);
        peek("off_c_rd", base + 32'd12, 32'd0);
        peek("off_c_ctrl", base, ctrl_off);
        peek("addr_lsb_ign", base + 32'd10, frozen);
    endtask

    initial begin
        int sel;
        int n;
        PrWE   = 1'b0;
        PrAddr = '0;
        PrWD   = '0;
        ExtInt = 4'hF;
        rst_n  = 1'b0;

        #17;
        check("rst_hwint", {26'd0, HWInt}, 32'd0);
        peek("rst_ctrl0", T0B, 32'd0);
        peek("rst_preset0", T0B + 32'd4, 32'd0);
        peek("rst_count0", T0B + 32'd8, 32'd0);
        #1;
        rst_n = 1'b1;
        reset_hist();
        repeat (3) step(1'b0, T0B, 32'd0);
        ext_rand = 1'b1;

        run_oneshot(0, 5, 1'b1, 2'b00, 1'b0);
        run_auto(0, 3, 1'b1, 3);
        run_oneshot(0, 2, 1'b0, 2'b00, 1'b1);
        run_disable(0, 12, 1'b1, 2'b00, 4);
        run_oneshot(1, 1, 1'b1, 2'b00, 1'b0);
        run_oneshot(0, 0, 1'b1, 2'b11, 1'b0);

        repeat (24) begin
            sel = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: begin
                    n = int'($urandom_range(0, 9));
                    run_oneshot(sel, n, 1'($urandom), ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(2, 3)),
                                1'($urandom));
                end
                1: begin
                    n = int'($urandom_range(0, 6));
                    run_auto(sel, n, 1'($urandom), int'($urandom_range(1, 2)));
                end
                default: begin
                    n = int'($urandom_range(4, 12));
                    run_disable(sel, n, 1'($urandom), 2'($urandom), int'($urandom_range(2, n)));
                end
            endcase
        end

        // Reset in the middle of a held one-shot interrupt.
        step(1'b1, T0B + 32'd4, 32'd3);
        step(1'b1, T0B, 32'h9);
        repeat (5) step(1'b0, T0B, 32'd0);
        irq_check("pre_rst_irq", 0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_hwint", {26'd0, HWInt}, 32'd0);
        peek("mid_rst_ctrl", T0B, 32'd0);
        peek("mid_rst_count", T0B + 32'd8, 32'd0);
        rst_n = 1'b1;
        reset_hist();
        repeat (3) step(1'b0, T0B, 32'd0);
        peek("post_rst_count", T0B + 32'd8, 32'd0);
        irq_check("post_rst_irq", 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
